sigmoid_forward: RTL and testbench

Single-precision (IEEE-754 binary32) sigmoid activation unit: the forward-pass producer of the sigmoid values that the derivative unit later consumes during backpropagation. Takes one float `x` per handshake and returns σ(x) using the PLAN piecewise-linear approximation, evaluated in internal fixed point. It is an iterative FSM with ready/valid on both sides and a fixed internal latency, and it sits between the neuron accumulator and the layer output register file.

---
 rtl/sigmoid_forward.sv | 162 ++++++++++++++++
 tb/tb_sigmoid_forward.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_forward.sv
// Binary32 sigmoid via the PLAN piecewise-linear approximation.
// Iterative: one operand in flight, fixed latency, ready/valid both sides.
module sigmoid_forward (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    SEGMENT,
    COMPLEMENT,
    NORMALIZE,
    PACK,
    DONE
  } state_t;

  localparam logic [24:0] ONE    = 25'h1000000;
  localparam logic [24:0] C_0500 = 25'h0800000;
  localparam logic [24:0] C_0625 = 25'h0A00000;
  localparam logic [24:0] C_0844 = 25'h0D80000;
  localparam logic [26:0] FX_1   = 27'h1000000;
  localparam logic [26:0] FX_2375 = 27'h2600000;
  localparam logic [26:0] FX_5   = 27'h5000000;
  localparam logic [31:0] QNAN   = 32'h7FC00000;

  state_t      state;
  logic [31:0] op;
  logic        s;
  logic        nan;
  logic        sat;
  logic        zero;
  logic [26:0] fx;
  logic [24:0] y;
  logic [4:0]  p;

  logic [7:0]  e;
  logic [26:0] mant;
  logic [26:0] fx_c;
  logic        nan_c;
  logic        sat_c;
  logic [24:0] y_seg;
  logic [4:0]  p_c;
  logic        zero_c;
  logic [7:0]  exp_c;
  logic [22:0] man_c;

  // fx is Q3.24: {1,M} carries 23 fraction bits, so the net shift is E-126
  always_comb begin
    e     = op[30:23];
    mant  = {3'b000, 1'b1, op[22:0]};
    fx_c  = '0;
    if (e == 8'd0)
      fx_c = '0;
    else if (e >= 8'd126)
      fx_c = mant << (e - 8'd126);
    else
      fx_c = mant >> (8'd126 - e);
    nan_c = (e == 8'hFF) && (op[22:0] != 23'd0);
    sat_c = (e >= 8'd130) || (fx_c >= FX_5);
  end

  always_comb begin
    y_seg = ONE;
    if (sat)
      y_seg = ONE;
    else if (fx < FX_1)
      y_seg = fx[26:2] + C_0500;
    else if (fx < FX_2375)
      y_seg = {1'b0, fx[26:3]} + C_0625;
    else
      y_seg = {3'b000, fx[26:5]} + C_0844;
  end

  always_comb begin
    p_c    = '0;
    zero_c = (y == 25'd0);
    for (int i = 0; i < 25; i++)
      if (y[i]) p_c = 5'(i);
  end

  always_comb begin
    exp_c = 8'd103 + {3'b000, p};
    man_c = 23'((y << (5'd24 - p)) >> 1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      op        <= '0;
      s         <= 1'b0;
      nan       <= 1'b0;
      sat       <= 1'b0;
      zero      <= 1'b0;
      fx        <= '0;
      y         <= '0;
      p         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!in_ready) begin
            in_ready <= 1'b1;
          end else if (in_valid) begin
            op       <= in_data;
            in_ready <= 1'b0;
            state    <= UNPACK;
          end
        end
        UNPACK: begin
          s     <= op[31];
          nan   <= nan_c;
          sat   <= sat_c;
          fx    <= fx_c;
          state <= SEGMENT;
        end
        SEGMENT: begin
          y     <= y_seg;
          state <= COMPLEMENT;
        end
        COMPLEMENT: begin
          if (s) y <= ONE - y;
          state <= NORMALIZE;
        end
        NORMALIZE: begin
          p     <= p_c;
          zero  <= zero_c;
          state <= PACK;
        end
        PACK: begin
          if (nan)
            out_data <= QNAN;
          else if (zero)
            out_data <= '0;
          else
            out_data <= {1'b0, exp_c, man_c};
          state <= DONE;
        end
        // first DONE cycle only raises valid, giving the 8-cycle cadence
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sigmoid_forward.sv
// Directed bench for sigmoid_forward.
// Expected results queue up on acceptance and are checked on output.
module tb_sigmoid_forward;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [31:0] sb[$];
  int          acc_q[$];

  logic [31:0] vx [12] = '{
    32'h00000000, 32'h3F000000, 32'h00000001, 32'h40000000,
    32'hC0000000, 32'h40400000, 32'hC0400000, 32'h40C00000,
    32'hC0C00000, 32'h7F800000, 32'hFF800000, 32'h7F800001
  };
  logic [31:0] ve [12] = '{
    32'h3F000000, 32'h3F200000, 32'h3F000000, 32'h3F600000,
    32'h3E000000, 32'h3F700000, 32'h3D800000, 32'h3F800000,
    32'h00000000, 32'h3F800000, 32'h00000000, 32'h7FC00000
  };
  logic [31:0] bx [3] = '{32'h3F000000, 32'hC0000000, 32'h40C00000};
  logic [31:0] be [3] = '{32'h3F200000, 32'h3E000000, 32'h3F800000};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  sigmoid_forward dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] x, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = x;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      acc = -1;
    end else begin
      acc = cyc + 1;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] exp);
    int acc;
    drive(x, acc);
    if (acc >= 0) begin
      sb.push_back(exp);
      acc_q.push_back(acc);
    end
  endtask

  task automatic collect(input string tag, output int t);
    int n;
    int acc;
    logic [31:0] exp;
    n = 0;
    t = -1;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else if (sb.size() == 0) begin
      check({tag, "_unexpected"}, 32'd1, 32'd0);
    end else begin
      exp = sb.pop_front();
      acc = acc_q.pop_front();
      t = cyc;
      check(tag, out_data, exp);
      check({tag, "_latency"}, 32'(cyc - acc), 32'd6);
    end
  endtask

  initial begin
    int t;
    int prev;
    int acc;
    int seen;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      send(vx[i], ve[i]);
      collect($sformatf("vec%0d", i), t);
    end

    // operand presented while busy must be dropped
    send(32'hC0400000, 32'h3D800000);
    in_valid = 1'b1;
    in_data  = 32'h40400000;
    for (int i = 0; i < 3; i++) begin
      check("busy_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    collect("busy_result", t);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("busy_no_extra", 32'(seen), 32'd0);

    out_ready = 1'b0;
    send(32'h40400000, 32'h3F700000);
    collect("bp_result", t);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_data", out_data, 32'h3F700000);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);

    prev = -1;
    for (int i = 0; i < 3; i++) begin
      send(bx[i], be[i]);
      collect($sformatf("b2b%0d", i), t);
      if (i > 0) check("b2b_spacing", 32'(t - prev), 32'd8);
      prev = t;
    end

    drive(32'h40000000, acc);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", out_data, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_ready_back", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst_no_result", 32'(seen), 32'd0);
    send(32'h00000000, 32'h3F000000);
    collect("after_rst", t);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
